// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline: load-use
// stall sequencing, branch flush, memory-busy freeze and EX operand forwarding.
module hazard_fwd_ctrl #(
  parameter int REG_AW    = 5,
  parameter int LU_STALLS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_write,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_active
);

  typedef enum logic {RUN, STALL} state_t;

  localparam bit        MULTI_STALL = (LU_STALLS > 1);
  localparam logic [1:0] CNT_INIT   = (LU_STALLS > 1) ? 2'(LU_STALLS - 2) : 2'd0;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       lu_hz;
  logic [1:0] fwd_a_p0, fwd_b_p0;
  logic [1:0] fwd_a_p1, fwd_b_p1;

  // EX match wins over MEM match; register 0 is never a forwarding source.
  function automatic logic [1:0] fwd_select(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] e_rd,
    input logic              e_rw,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_rw
  );
    if (e_rw && (e_rd != '0) && (e_rd == src))
      return 2'b01;
    else if (m_rw && (m_rd != '0) && (m_rd == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign lu_hz = ex_memread && ex_regwrite && (ex_rd != '0) &&
                 ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));

  assign fwd_a_p0 = fwd_select(id_rs, ex_rd, ex_regwrite, mem_rd, mem_regwrite);
  assign fwd_b_p0 = fwd_select(id_rt, ex_rd, ex_regwrite, mem_rd, mem_regwrite);

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    stall_active = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_nxt   = RUN;
      cnt_nxt     = 2'd0;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else begin
      case (state)
        STALL: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_bubble  = 1'b1;
          stall_active = 1'b1;
          if (cnt == 2'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 2'd1;
        end
        RUN: begin
          if (lu_hz) begin
            // First bubble is issued immediately; a pending branch is ignored
            // because its compare operands are not valid yet.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            stall_active = 1'b1;
            if (MULTI_STALL) begin
              state_nxt = STALL;
              cnt_nxt   = CNT_INIT;
            end
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ID -> EX boundary: reset forces a bubble load, which clears the selects.
  always_ff @(posedge clk) begin
    if (idex_write) begin
      fwd_a_p1 <= idex_bubble ? 2'b00 : fwd_a_p0;
      fwd_b_p1 <= idex_bubble ? 2'b00 : fwd_b_p0;
    end
  end

  assign fwd_a_sel = fwd_a_p1;
  assign fwd_b_sel = fwd_b_p1;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: one instance with single-cycle load-use
// stalls and one with three, both fed the same pipeline stimulus.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_uses_rs, id_uses_rt, ex_regwrite, ex_memread, mem_regwrite;
  logic       branch_taken, mem_busy;

  logic       pc_write1, ifid_write1, ifid_flush1, idex_write1, idex_bubble1, stall_active1;
  logic [1:0] fwd_a1, fwd_b1;
  logic       pc_write3, ifid_write3, ifid_flush3, idex_write3, idex_bubble3, stall_active3;
  logic [1:0] fwd_a3, fwd_b3;
  logic [5:0] ctl1, ctl3;

  int n_assert = 0;
  int n_fail   = 0;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, stall_active}
  localparam logic [5:0] C_RST = 6'b001110;
  localparam logic [5:0] C_STL = 6'b000111;
  localparam logic [5:0] C_BR  = 6'b111100;
  localparam logic [5:0] C_RUN = 6'b110100;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_AW(5), .LU_STALLS(1)) dut1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
    .idex_write(idex_write1), .idex_bubble(idex_bubble1),
    .fwd_a_sel(fwd_a1), .fwd_b_sel(fwd_b1), .stall_active(stall_active1)
  );

  hazard_fwd_ctrl #(.REG_AW(5), .LU_STALLS(3)) dut3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write3), .ifid_write(ifid_write3), .ifid_flush(ifid_flush3),
    .idex_write(idex_write3), .idex_bubble(idex_bubble3),
    .fwd_a_sel(fwd_a3), .fwd_b_sel(fwd_b3), .stall_active(stall_active3)
  );

  assign ctl1 = {pc_write1, ifid_write1, ifid_flush1, idex_write1, idex_bubble1, stall_active1};
  assign ctl3 = {pc_write3, ifid_write3, ifid_flush3, idex_write3, idex_bubble3, stall_active3};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] erd, input logic erw,
                       input logic emr, input logic [4:0] mrd, input logic mrw,
                       input logic br, input logic busy);
    id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    ex_rd = erd; ex_regwrite = erw; ex_memread = emr;
    mem_rd = mrd; mem_regwrite = mrw;
    branch_taken = br; mem_busy = busy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_ctl1", 8'(ctl1), 8'(C_RST));
    chk("reset_ctl3", 8'(ctl3), 8'(C_RST));
    step();
    chk("reset_fwd", {4'd0, fwd_a1, fwd_b1}, 8'd0);
    reset = 1'b0;

    // add $3 in EX, consumer reads rs=$3
    drive(3, 1, 7, 1, 3, 1, 0, 0, 0, 0, 0);
    chk("exfwd_ctl", 8'(ctl1), 8'(C_RUN));
    step();
    chk("exfwd_a", 8'(fwd_a1), 8'd1);
    chk("exfwd_b", 8'(fwd_b1), 8'd0);

    // lw $4 in EX, consumer reads rt=$4, single stall
    do_reset();
    drive(2, 1, 4, 1, 4, 1, 1, 0, 0, 0, 0);
    chk("lu1_ctl", 8'(ctl1), 8'(C_STL));
    step();
    chk("lu1_bubble_fwd", 8'(fwd_b1), 8'd0);
    drive(2, 1, 4, 1, 0, 0, 0, 4, 1, 0, 0);
    chk("lu1_resume_ctl", 8'(ctl1), 8'(C_RUN));
    step();
    chk("lu1_fwd_b", 8'(fwd_b1), 8'd2);
    chk("lu1_fwd_a", 8'(fwd_a1), 8'd0);

    // load matches rt but rt is unused: no stall
    drive(2, 1, 4, 0, 4, 1, 1, 0, 0, 0, 0);
    chk("lu_unused_ctl", 8'(ctl1), 8'(C_RUN));
    step();

    // EX priority over MEM, MEM-only, and register 0
    drive(5, 1, 0, 0, 5, 1, 0, 5, 1, 0, 0);
    step();
    chk("prio_ex", 8'(fwd_a1), 8'd1);
    drive(5, 1, 0, 0, 6, 1, 0, 5, 1, 0, 0);
    step();
    chk("mem_only", 8'(fwd_a1), 8'd2);
    drive(0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    step();
    chk("r0_a", 8'(fwd_a1), 8'd0);
    chk("r0_b", 8'(fwd_b1), 8'd0);

    // load-use with branch: stall wins; then branch alone flushes once
    do_reset();
    drive(2, 1, 4, 1, 4, 1, 1, 0, 0, 1, 0);
    chk("lu_br_ctl", 8'(ctl1), 8'(C_STL));
    step();
    drive(2, 1, 4, 1, 0, 0, 0, 4, 1, 1, 0);
    chk("br_ctl", 8'(ctl1), 8'(C_BR));
    step();
    drive(2, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("br_after_ctl", 8'(ctl1), 8'(C_RUN));
    step();

    // busy freeze holds a nonzero forward select and ignores branch
    do_reset();
    drive(3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    step();
    chk("hold_pre", 8'(fwd_a1), 8'd1);
    drive(3, 1, 0, 0, 9, 1, 0, 0, 0, 1, 1);
    chk("busy_ctl1", 8'(ctl1[5:1]), 8'd0);
    step();
    chk("busy_hold_a", 8'(fwd_a1), 8'd1);
    drive(3, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    step();
    chk("busy_release_a", 8'(fwd_a1), 8'd0);

    // three-bubble stall interrupted by two busy cycles
    do_reset();
    drive(2, 1, 4, 1, 4, 1, 1, 0, 0, 0, 0);
    chk("lu3_b1", 8'(ctl3), 8'(C_STL));
    step();
    drive(2, 1, 4, 1, 0, 0, 0, 4, 1, 0, 0);
    chk("lu3_b2", 8'(ctl3), 8'(C_STL));
    step();
    drive(2, 1, 4, 1, 0, 0, 0, 4, 1, 0, 1);
    chk("lu3_busy1", 8'(ctl3[5:1]), 8'd0);
    step();
    chk("lu3_busy2", 8'(ctl3[5:1]), 8'd0);
    chk("lu3_busy_fwd", 8'(fwd_b3), 8'd0);
    step();
    drive(2, 1, 4, 1, 0, 0, 0, 4, 1, 0, 0);
    chk("lu3_b3", 8'(ctl3), 8'(C_STL));
    step();
    chk("lu3_b3_fwd", 8'(fwd_b3), 8'd0);
    chk("lu3_run", 8'(ctl3), 8'(C_RUN));
    step();
    chk("lu3_fwd_b", 8'(fwd_b3), 8'd2);

    // reset in the middle of a multi-cycle stall
    do_reset();
    drive(2, 1, 4, 1, 4, 1, 1, 0, 0, 0, 0);
    chk("rst_stall_b1", 8'(ctl3), 8'(C_STL));
    step();
    reset = 1'b1;
    #1;
    chk("rst_stall_ctl", 8'(ctl3), 8'(C_RST));
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall_fwd", {4'd0, fwd_a3, fwd_b3}, 8'd0);
    chk("rst_stall_run", 8'(ctl3), 8'(C_RUN));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
